// File: rtl/sgemm_feeder_pkg.sv
// Shared types and constants for the SGEMM feeder front end.
package sgemm_feeder_pkg;

  localparam int LINES_PER_ROW = 256;
  localparam int LINE_W        = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/feeders_a_fetch_fifo.sv
// Show-ahead synchronous FIFO: head_o always presents the oldest entry.
// DEPTH must be a power of two; pointers wrap naturally.
module feeders_a_fetch_fifo
  import sgemm_feeder_pkg::*;
#(
  parameter int W     = LINE_W,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  // Storage array: no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/feeders_a_fetcher.sv
// Fetches NUM_ROWS*256-line A workloads from memory and streams them in
// order into feeders_a. Requests are credit-limited by the local response
// FIFO; writes honour feeders_a_full plus a 2-cycle gap at each workload end.
// Optional FEEDERS_A_FETCH_PERF_EN adds stall counters.
module feeders_a_fetcher
  import sgemm_feeder_pkg::*;
#(
  parameter int NUM_ROWS        = 2,
  parameter int ADDR_W          = 42,
  parameter int FIFO_DEPTH      = 64,
  parameter int MAX_WORKLOADS_W = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [MAX_WORKLOADS_W-1:0] num_workloads,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_req_valid,
  output logic [ADDR_W-1:0]          rd_req_addr,
  input  logic                       rd_req_almfull,
  input  logic                       rsp_valid,
  input  logic [LINE_W-1:0]          rsp_data,
  output logic                       wr_en,
  output logic [LINE_W-1:0]          data_out,
  input  logic                       feeders_a_full
`ifdef FEEDERS_A_FETCH_PERF_EN
  , output logic [31:0]              perf_full_stall
  , output logic [31:0]              perf_empty_stall
`endif
);
  localparam int LPW   = NUM_ROWS * LINES_PER_ROW;
  localparam int LN_W  = $clog2(LPW);
  localparam int TOT_W = MAX_WORKLOADS_W + LN_W;
  localparam int CR_W  = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t               state_q, state_d;
  logic [ADDR_W-1:0]          base_q;
  logic [MAX_WORKLOADS_W-1:0] nwl_q, wl_cnt_q;
  logic [TOT_W-1:0]           total_q, req_cnt_q;
  logic [CR_W-1:0]            credits_q;
  logic [LN_W-1:0]            line_cnt_q;
  logic [1:0]                 bubble_q;
  logic                       wr_en_q, last_wr_q;
  logic [LINE_W-1:0]          data_q, fifo_head;
  logic                       fifo_empty, fifo_full;
  logic [CR_W-1:0]            fifo_count;
  logic active, start_ok, req, push, pop, line_last, wl_last;

  assign active    = (state_q == FETCH) || (state_q == DRAIN);
  assign start_ok  = start && (state_q == IDLE);
  assign req       = (state_q == FETCH) && !rd_req_almfull && (credits_q != '0);
  // Responses outside a fetch are stale (e.g. after reset) and dropped.
  assign push      = rsp_valid && active;
  assign pop       = active && !fifo_empty && !feeders_a_full && (bubble_q == 2'd0);
  assign line_last = (line_cnt_q == LN_W'(LPW - 1));
  assign wl_last   = (wl_cnt_q == nwl_q - MAX_WORKLOADS_W'(1));

  feeders_a_fetch_fifo #(.W(LINE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (rsp_data),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Next-state logic for the fetch sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_workloads == '0) ? DONE : FETCH;
      FETCH:   if (req && (req_cnt_q == total_q - TOT_W'(1))) state_d = DRAIN;
      DRAIN:   if (wr_en_q && last_wr_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State, request/credit accounting and per-workload line tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      nwl_q      <= '0;
      total_q    <= '0;
      req_cnt_q  <= '0;
      credits_q  <= '0;
      line_cnt_q <= '0;
      wl_cnt_q   <= '0;
      bubble_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        base_q     <= base_addr;
        nwl_q      <= num_workloads;
        total_q    <= TOT_W'(num_workloads) * TOT_W'(LPW);
        req_cnt_q  <= '0;
        credits_q  <= CR_W'(FIFO_DEPTH);
        line_cnt_q <= '0;
        wl_cnt_q   <= '0;
        bubble_q   <= '0;
      end else begin
        if (req) req_cnt_q <= req_cnt_q + TOT_W'(1);
        case ({req, pop})
          2'b10:   credits_q <= credits_q - CR_W'(1);
          2'b01:   credits_q <= credits_q + CR_W'(1);
          default: ;
        endcase
        if (pop) begin
          line_cnt_q <= line_last ? '0 : line_cnt_q + LN_W'(1);
          if (line_last) begin
            wl_cnt_q <= wl_cnt_q + MAX_WORKLOADS_W'(1);
            // feeders_a_full is registered downstream; give it time to rise.
            bubble_q <= 2'd2;
          end
        end else if (bubble_q != 2'd0) begin
          bubble_q <= bubble_q - 2'd1;
        end
      end
    end
  end

  // Registered write port towards feeders_a.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      last_wr_q <= 1'b0;
      data_q    <= '0;
    end else begin
      wr_en_q   <= pop;
      last_wr_q <= pop && line_last && wl_last;
      if (pop) data_q <= fifo_head;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign rd_req_valid = req;
  assign rd_req_addr  = base_q + ADDR_W'(req_cnt_q);
  assign wr_en        = wr_en_q;
  assign data_out     = data_q;

  // Credits guarantee the FIFO can never be pushed while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && fifo_full && !pop));
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (32'(credits_q) + 32'(fifo_count)) <= 32'(FIFO_DEPTH));

`ifdef FEEDERS_A_FETCH_PERF_EN
  logic [31:0] perf_full_q, perf_empty_q;

  // Saturating stall counters, cleared on each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else if (start_ok) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else if (active) begin
      if (!fifo_empty && feeders_a_full && (perf_full_q != '1))
        perf_full_q <= perf_full_q + 32'd1;
      if (fifo_empty && (perf_empty_q != '1))
        perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign perf_full_stall  = perf_full_q;
  assign perf_empty_stall = perf_empty_q;
`endif

endmodule

// File: tb/tb_feeders_a_fetcher.sv
// Randomized bench for feeders_a_fetcher with an in-order memory model and
// a line-level scoreboard predicting requests, writes, gaps and done.
module tb_feeders_a_fetcher;
  localparam int AW  = 42;
  localparam int WW  = 10;
  localparam int FD  = 64;
  localparam int LAT = 20;
  localparam int LPW = 2 * 256;

  logic           clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [WW-1:0]  num_workloads = '0;
  logic           busy, done, rd_req_valid, wr_en;
  logic [AW-1:0]  rd_req_addr;
  logic           rd_req_almfull = 1'b0, rsp_valid = 1'b0, feeders_a_full = 1'b0;
  logic [511:0]   rsp_data = '0, data_out;
`ifdef FEEDERS_A_FETCH_PERF_EN
  logic [31:0]    perf_full_stall, perf_empty_stall;
`endif

  feeders_a_fetcher #(.NUM_ROWS(2), .ADDR_W(AW), .FIFO_DEPTH(FD), .MAX_WORKLOADS_W(WW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_workloads(num_workloads), .busy(busy), .done(done),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr),
    .rd_req_almfull(rd_req_almfull), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_en(wr_en), .data_out(data_out), .feeders_a_full(feeders_a_full)
`ifdef FEEDERS_A_FETCH_PERF_EN
    , .perf_full_stall(perf_full_stall), .perf_empty_stall(perf_empty_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total_n = 0, bad_n = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] data_for(input logic [AW-1:0] a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = (a[31:0] * (i + 7)) ^ 32'h9E3779B9;
    return d;
  endfunction

  // Outstanding memory reads: address and the cycle whose rising edge
  // carries the response into the DUT.
  logic [AW-1:0] mq_addr[$];
  int            mq_rdy[$];

  // mode: 0 clean (+ ignored start mid-run), 1 hold full 200 cycles after
  // workload 0, 2 almfull toggles every 3 cycles, 3 random full/almfull.
  task automatic run_job(input logic [AW-1:0] base, input int nwl, input int mode,
                         input int abort_at, output bit aborted);
    int total, req_i, wr_i, buffered, bnd, done_n, done_at, last_wr, max_out, c0, hold_left;
    bit pushed, exp_wr, act, held, fin;
    logic [AW-1:0] ea;
    total = nwl * LPW; req_i = 0; wr_i = 0; buffered = 0; bnd = -10;
    done_n = 0; done_at = -1; last_wr = -1; max_out = 0; hold_left = 0;
    pushed = 0; exp_wr = 0; held = 0; fin = 0; aborted = 0;
    mq_addr.delete(); mq_rdy.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; num_workloads = WW'(nwl);
    c0 = cyc; act = (nwl != 0);
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mode == 0 && cyc == c0 + 50) begin
        start = 1'b1; base_addr = '0; num_workloads = 10'd5;
      end
      // Registered outputs reflect the last rising edge.
      chk("wr_en", wr_en, exp_wr);
      if (wr_en) begin
        ea = base + AW'(wr_i);
        chk("wr_data", data_out, data_for(ea));
        if (wr_i % LPW == LPW - 1) bnd = cyc;
        wr_i++;
        last_wr = cyc;
      end
      if (cyc == c0 + 1) chk("busy_on", busy, 1'b1);
      if (done_at >= 0 && cyc == done_at + 1) begin
        chk("busy_off", busy, 1'b0);
        fin = 1;
        break;
      end
      if (done) begin
        done_n++;
        done_at = cyc;
        chk("done_cyc", cyc, act ? last_wr + 1 : c0 + 1);
      end
      buffered = buffered + int'(pushed) - int'(wr_en);
      // Drive this cycle's inputs.
      case (mode)
        1: begin
          if (!held && wr_i >= LPW) begin held = 1; hold_left = 200; end
          feeders_a_full = (hold_left > 0);
          if (hold_left > 0) hold_left--;
        end
        3: feeders_a_full = ($urandom_range(0, 4) == 0);
        default: feeders_a_full = 1'b0;
      endcase
      case (mode)
        2: rd_req_almfull = ((cyc / 3) % 2) == 1;
        3: rd_req_almfull = ($urandom_range(0, 3) == 0);
        default: rd_req_almfull = 1'b0;
      endcase
      if (mq_addr.size() > 0 && mq_rdy[0] <= cyc + 1) begin
        rsp_valid = 1'b1;
        rsp_data  = data_for(mq_addr.pop_front());
        void'(mq_rdy.pop_front());
      end else begin
        rsp_valid = 1'b0;
      end
      pushed = rsp_valid && act;
      exp_wr = act && (buffered > 0) && !feeders_a_full && (cyc + 1 >= bnd + 3);
      // Combinational request port settles on the new inputs.
      #1;
      if (rd_req_valid) begin
        chk("req_almfull", rd_req_almfull, 1'b0);
        ea = base + AW'(req_i);
        chk("req_addr", rd_req_addr, ea);
        mq_addr.push_back(rd_req_addr);
        mq_rdy.push_back(cyc + 1 + LAT);
        req_i++;
        if (req_i - wr_i > max_out) max_out = req_i - wr_i;
        chk("req_credit", (req_i - wr_i) <= FD, 1'b1);
        chk("req_over", req_i <= total, 1'b1);
      end
      if (abort_at > 0 && req_i >= abort_at) begin
        aborted = 1;
        return;
      end
    end
    chk("timeout", fin, 1'b1);
    chk("req_total", req_i, total);
    chk("wr_total", wr_i, total);
    chk("done_cnt", done_n, 1);
    if (mode == 1) chk("max_outst", max_out, FD);
    feeders_a_full = 1'b0; rd_req_almfull = 1'b0; rsp_valid = 1'b0;
  endtask

  initial begin
    bit ab;
    logic [AW-1:0] rb;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", rd_req_valid, 1'b0);
    chk("rst_addr", rd_req_addr, '0);
    chk("rst_wr", wr_en, 1'b0);
    chk("rst_data", data_out, '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    run_job(42'h1000, 1, 0, 0, ab);
    run_job(42'h2_0000, 3, 1, 0, ab);
    run_job(42'h3_0000_0123, 2, 2, 0, ab);
    run_job(42'h555, 0, 0, 0, ab);

    // Abort mid-fetch with an asynchronous reset, then refetch.
    run_job(42'h8000, 1, 3, 100, ab);
    chk("abort_hit", ab, 1'b1);
    chk("abort_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_req", rd_req_valid, 1'b0);
    chk("arst_addr", rd_req_addr, '0);
    chk("arst_wr", wr_en, 1'b0);
    chk("arst_data", data_out, '0);
    rsp_valid = 1'b0; start = 1'b0; feeders_a_full = 1'b0; rd_req_almfull = 1'b0;
    mq_addr.delete(); mq_rdy.delete();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    // Late responses from the aborted fetch must be dropped.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rsp_valid = 1'b1;
      rsp_data  = data_for(AW'(i));
      chk("stale_wr", wr_en, 1'b0);
    end
    @(negedge clk);
    rsp_valid = 1'b0;
    chk("stale_busy", busy, 1'b0);
    run_job(42'h8000, 1, 3, 0, ab);

    rb = AW'({$urandom, $urandom});
    run_job(rb, 2, 3, 0, ab);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
